// File: rtl/counter_input_cond_if.sv
// counter_input_cond_if: raw board inputs in, conditioned counter controls out
interface counter_input_cond_if;
    logic btn_load_raw;
    logic sw_updn_raw;
    logic load;
    logic up_down;
    logic tick;
    modport master (output btn_load_raw, sw_updn_raw, input load, up_down, tick);
    modport slave (input btn_load_raw, sw_updn_raw, output load, up_down, tick);
endinterface

// File: rtl/counter_input_cond.sv
// counter_input_cond: synchronise and debounce button/switch, one-shot load pulse, prescaled tick
module counter_input_cond #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TICK_DIV        = 8
) (
    input logic clk,
    input logic reset,
    counter_input_cond_if.slave bus
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PW = $clog2(TICK_DIV);
    typedef enum logic {IDLE, HELD} state_t;
    logic [SYNC_STAGES-1:0] sync_btn, sync_updn;
    logic [1:0] s, d;
    logic [CW-1:0] cnt [2];
    logic [PW-1:0] pre;
    logic pre_wrap, load_nxt;
    state_t state, state_nxt;
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            sync_btn  <= '0;
            sync_updn <= '0;
        end else begin
            sync_btn  <= {sync_btn[SYNC_STAGES-2:0], bus.btn_load_raw};
            sync_updn <= {sync_updn[SYNC_STAGES-2:0], bus.sw_updn_raw};
        end
    assign s = {sync_updn[SYNC_STAGES-1], sync_btn[SYNC_STAGES-1]};
    // index 0 debounces the button, index 1 the up/down switch
    for (genvar i = 0; i < 2; i++) begin : g_db
        always_ff @(posedge clk or posedge reset)
            if (reset) begin
                d[i]   <= 1'b0;
                cnt[i] <= '0;
            end else if (s[i] == d[i]) begin
                cnt[i] <= '0;
            end else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                d[i]   <= s[i];
                cnt[i] <= '0;
            end else begin
                cnt[i] <= cnt[i] + 1'b1;
            end
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    always_comb state_nxt = d[0] ? HELD : IDLE;
    always_comb load_nxt = (state == IDLE) && d[0];
    assign pre_wrap = pre == PW'(TICK_DIV - 1);
    // a load restarts the tick period so the first tick after it is a full period away
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            pre      <= '0;
            bus.tick <= 1'b0;
            bus.load <= 1'b0;
        end else begin
            pre      <= (load_nxt || pre_wrap) ? '0 : pre + 1'b1;
            bus.tick <= pre_wrap && !load_nxt;
            bus.load <= load_nxt;
        end
    assign bus.up_down = d[1];
endmodule

// File: tb/tb_counter_input_cond.sv
// tb_counter_input_cond: directed scenario tasks with hand-computed expectations
module tb_counter_input_cond;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int total = 0;
    int bad = 0;
    counter_input_cond_if bus ();
    counter_input_cond dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        bus.btn_load_raw = 1'b0;
        bus.sw_updn_raw  = 1'b0;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        bus.btn_load_raw = 1'b1;
        bus.sw_updn_raw  = 1'b1;
        reset = 1'b1;
        step();
        step();
        total++;
        if ({bus.load, bus.up_down, bus.tick} !== 3'b000) begin
            bad++;
            $display("FAIL reset_hold: got %b want 000", {bus.load, bus.up_down, bus.tick});
        end
        apply_reset();
        total++;
        if ({bus.load, bus.up_down, bus.tick} !== 3'b000) begin
            bad++;
            $display("FAIL reset_release: got %b want 000", {bus.load, bus.up_down, bus.tick});
        end
    endtask

    task automatic test_free_tick();
        apply_reset();
        for (int k = 0; k < 24; k++) begin
            step();
            total++;
            if ({bus.load, bus.up_down, bus.tick} !== {2'b00, (k % 8) == 7}) begin
                bad++;
                $display("FAIL free_tick edge %0d: got %b want %b", k,
                         {bus.load, bus.up_down, bus.tick}, {2'b00, (k % 8) == 7});
            end
        end
    endtask

    task automatic test_glitch();
        apply_reset();
        bus.btn_load_raw = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            if (k == 2) bus.btn_load_raw = 1'b0;
            total++;
            if (bus.load !== 1'b0) begin
                bad++;
                $display("FAIL glitch edge %0d: load=%b want 0", k, bus.load);
            end
        end
    endtask

    task automatic test_press_hold();
        logic exp_tick;
        apply_reset();
        bus.btn_load_raw = 1'b1;
        for (int k = 0; k < 50; k++) begin
            step();
            if (k == 39) bus.btn_load_raw = 1'b0;
            exp_tick = (k > 6) && ((k - 6) % 8 == 0);
            total++;
            if (bus.load !== (k == 6) || bus.tick !== exp_tick) begin
                bad++;
                $display("FAIL press_hold edge %0d: load=%b tick=%b want load=%b tick=%b",
                         k, bus.load, bus.tick, k == 6, exp_tick);
            end
        end
    endtask

    task automatic test_bounce();
        logic [3:0] pat;
        pat = 4'b0101;
        apply_reset();
        for (int k = 0; k < 20; k++) begin
            bus.sw_updn_raw = (k < 4) ? pat[k] : 1'b1;
            step();
            total++;
            if (bus.up_down !== (k >= 9)) begin
                bad++;
                $display("FAIL bounce edge %0d: up_down=%b want %b", k, bus.up_down, k >= 9);
            end
        end
    endtask

    task automatic test_load_tick_clash();
        apply_reset();
        step();
        bus.btn_load_raw = 1'b1;
        for (int k = 1; k < 21; k++) begin
            step();
            total++;
            if (bus.load !== (k == 7) || bus.tick !== (k == 15)) begin
                bad++;
                $display("FAIL load_tick_clash edge %0d: load=%b tick=%b want load=%b tick=%b",
                         k, bus.load, bus.tick, k == 7, k == 15);
            end
        end
        bus.btn_load_raw = 1'b0;
    endtask

    task automatic test_reset_mid_debounce();
        apply_reset();
        bus.sw_updn_raw = 1'b1;
        for (int k = 0; k < 8; k++) step();
        total++;
        if (bus.up_down !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset_updn: up_down=%b want 1", bus.up_down);
        end
        bus.btn_load_raw = 1'b1;
        for (int k = 0; k < 3; k++) step();
        #2 reset = 1'b1;
        #1;
        total++;
        if ({bus.load, bus.up_down, bus.tick} !== 3'b000) begin
            bad++;
            $display("FAIL async_reset: got %b want 000", {bus.load, bus.up_down, bus.tick});
        end
        step();
        reset = 1'b0;
        for (int k = 0; k < 13; k++) begin
            step();
            total++;
            if ({bus.load, bus.up_down, bus.tick} !== {k == 6, k >= 5, 1'b0}) begin
                bad++;
                $display("FAIL after_reset edge %0d: got %b want %b", k,
                         {bus.load, bus.up_down, bus.tick}, {k == 6, k >= 5, 1'b0});
            end
        end
    endtask

    initial begin
        bus.btn_load_raw = 1'b0;
        bus.sw_updn_raw  = 1'b0;
        test_reset();
        test_free_tick();
        test_glitch();
        test_press_hold();
        test_bounce();
        test_load_tick_clash();
        test_reset_mid_debounce();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
